if_burst_sched: RTL and testbench
=================================

// Module: if_burst_sched
// PURPOSE
//  Burst scheduler for the off-chip interface. Takes level requests from the GBF fill/drain
//  request generators (CFG, FLGWEI, WEI, FLGACT, ACT, FLGOFM, OFM) and grants one channel at a time.
//  Holds the grant, IF_Cfg and IF_RdWr stable through a handshake plus a fixed-length data burst.
//  Sits between the per-GBF request logic and the interface port.
// PARAMETERS
//  BURST_LEN  16  data beats (IF_Val cycles) per granted transaction; >=2
//  CNT_W      4   beat counter width = clog2(BURST_LEN)
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      synchronous active-low reset
//  Reset      in   1      synchronous soft clear, active high; aborts current burst
//  Req        in   7      level requests [0]CFG [1]FLGWEI [2]WEI [3]FLGACT [4]ACT [5]FLGOFM [6]OFM
//  IF_Rdy     in   1      interface accepts request (sampled only in REQ)
//  IF_Val     in   1      one data beat transferred (sampled only in XFER)
//  IF_Req     out  1      request level to interface
//  IF_Cfg     out  4      channel code: CFG 0, FLGWEI 8, WEI 6, FLGACT 4, ACT 2, FLGOFM 10, OFM 11, none 15
//  IF_RdWr    out  1      1 = read (CFG/WEI/ACT paths), 0 = write (OFM paths)
//  Gnt        out  7      one-hot granted channel, same bit map as Req
//  Done       out  7      one-cycle one-hot pulse when granted burst completes
//  Busy       out  1      1 in any state other than IDLE
//  BeatCnt    out  CNT_W  beats received in current burst
// BEHAVIOUR
//  All outputs registered or decoded from registered state; no comb path from inputs to outputs.
//  Reset values (rst_n=0 or Reset=1, both effective at the next edge): state IDLE, IF_Req 0,
//   IF_Cfg 15, IF_RdWr 1, Gnt 0, Done 0, Busy 0, BeatCnt 0. rst_n also sets RR pointer to FLGWEI;
//   Reset leaves the RR pointer unchanged. Aborted bursts produce no Done.
//  FSM IDLE -> REQ -> XFER -> DONE -> IDLE.
//  IDLE: if Req!=0, select winner, latch Gnt/IF_Cfg/IF_RdWr, go to REQ. Otherwise stay.
//   Winner selection uses fixed priority FLGOFM > OFM > CFG, then round-robin among FLGWEI/WEI/FLGACT/ACT.
//   Round-robin search starts at the channel after the last completed read-data grant.
//  REQ: IF_Req=1. On IF_Rdy=1 go to XFER with BeatCnt=0. IF_Req is 0 from the next cycle.
//  XFER: each IF_Val=1 increments BeatCnt; bubbles hold the count.
//   IF_Val=1 with BeatCnt==BURST_LEN-1 -> DONE, with BeatCnt wrapping to 0.
//  DONE: Done=Gnt for exactly one cycle. Then Gnt->0, IF_Cfg->15, IF_RdWr->1.
//   RR pointer is updated if the grant was FLGWEI..ACT. Go to IDLE.
//  Latency: Req rise in IDLE -> IF_Req=1 after 1 cycle. Back-to-back bursts have a 1-cycle IDLE gap.
//   Minimum burst occupancy is BURST_LEN+3 cycles.
//  Req bits dropping after grant are ignored; the burst always completes.
//   New Req bits are only evaluated in IDLE.
//  IF_Val outside XFER and IF_Rdy outside REQ are ignored. IF_Rdy and IF_Val together in REQ:
//   only IF_Rdy counts, and that beat is not counted.
//  Reset has priority over all transitions, including the DONE pulse cycle.
// TESTING (BURST_LEN=4)
//  Req=7'b0010000 at cyc0, IF_Rdy at cyc3, IF_Val cyc4..7 -> IF_Req=1 cyc1..3, IF_Cfg=2, IF_RdWr=1,
//   Done=7'b0010000 at cyc8 only.
//  Req=7'b1100001 held -> Gnt sequence FLGOFM(Cfg10,RdWr0), FLGOFM, ...; drop bit5 -> OFM(11);
//   drop bit6 -> CFG(0).
//  Req[4:1]=4'hF held, CFG/OFM low -> grants FLGWEI, WEI, FLGACT, ACT, FLGWEI in order.
//  XFER with IF_Val=1,0,1,0,0,1,1 -> BeatCnt 1,1,2,2,2,3,0; Done pulses after the 4th valid beat.
//  Reset=1 after 2 beats -> next cycle IDLE, IF_Cfg=15, Gnt=0, no Done; next grant follows old RR pointer.
//  rst_n=0 during REQ with IF_Rdy=1 -> next edge all reset values; no XFER entered.

Source files
------------

// File: rtl/if_burst_sched_if.sv
// Bundle between the per-GBF request generators, the burst scheduler and the
// off-chip interface port. The master side is the scheduler; the slave side
// is whatever drives requests and interface responses.
interface if_burst_sched_if #(
    parameter int CNT_W = 4
);
    logic [6:0]       Req;
    logic             IF_Rdy;
    logic             IF_Val;
    logic             IF_Req;
    logic [3:0]       IF_Cfg;
    logic             IF_RdWr;
    logic [6:0]       Gnt;
    logic [6:0]       Done;
    logic             Busy;
    logic [CNT_W-1:0] BeatCnt;

    modport master (
        input  Req, IF_Rdy, IF_Val,
        output IF_Req, IF_Cfg, IF_RdWr, Gnt, Done, Busy, BeatCnt
    );

    modport slave (
        output Req, IF_Rdy, IF_Val,
        input  IF_Req, IF_Cfg, IF_RdWr, Gnt, Done, Busy, BeatCnt
    );
endinterface

// File: rtl/if_burst_sched.sv
// Burst scheduler: picks one GBF channel, requests the interface, counts a
// fixed-length data burst and pulses Done for the granted channel.
// Priority is FLGOFM > OFM > CFG, then round-robin over FLGWEI/WEI/FLGACT/ACT.
module if_burst_sched #(
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Reset,
    if_burst_sched_if.master  bus
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           stateReg;
    logic [6:0]       gntReg;
    logic [6:0]       doneReg;
    logic [3:0]       cfgReg;
    logic             rdWrReg;
    logic             ifReqReg;
    logic             busyReg;
    logic [CNT_W-1:0] cntReg;
    // Index 0..3 maps to Req bits 1..4 (FLGWEI, WEI, FLGACT, ACT).
    logic [1:0]       rrPtrReg;

    logic [1:0] rotIdx [4];
    logic       rrHit;
    logic [1:0] rrSel;
    logic [6:0] winGnt;
    logic [3:0] winCfg;
    logic       winRdWr;
    logic [1:0] rrAfter;

    // Round-robin candidate order, starting at the pointer and wrapping.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rotIdx[gi] = rrPtrReg + 2'(gi);
        end
    endgenerate

    // First requesting read-data channel in round-robin order.
    always_comb begin
        rrHit = 1'b0;
        rrSel = rrPtrReg;
        for (int k = 3; k >= 0; k--) begin
            if (bus.Req[3'(rotIdx[k]) + 3'd1]) begin
                rrHit = 1'b1;
                rrSel = rotIdx[k];
            end
        end
    end

    // Winner one-hot: fixed-priority channels first, then round-robin.
    always_comb begin
        winGnt = '0;
        if (bus.Req[5])      winGnt[5] = 1'b1;
        else if (bus.Req[6]) winGnt[6] = 1'b1;
        else if (bus.Req[0]) winGnt[0] = 1'b1;
        else if (rrHit)      winGnt[3'(rrSel) + 3'd1] = 1'b1;
    end

    // Channel code and direction of the winner.
    always_comb begin
        case (winGnt)
            7'b0000001: winCfg = 4'd0;
            7'b0000010: winCfg = 4'd8;
            7'b0000100: winCfg = 4'd6;
            7'b0001000: winCfg = 4'd4;
            7'b0010000: winCfg = 4'd2;
            7'b0100000: winCfg = 4'd10;
            7'b1000000: winCfg = 4'd11;
            default:    winCfg = 4'd15;
        endcase
        winRdWr = ~(winGnt[5] | winGnt[6]);
    end

    // Next round-robin start: the channel after the one just completed.
    always_comb begin
        case (gntReg[4:1])
            4'b0001: rrAfter = 2'd1;
            4'b0010: rrAfter = 2'd2;
            4'b0100: rrAfter = 2'd3;
            4'b1000: rrAfter = 2'd0;
            default: rrAfter = rrPtrReg;
        endcase
    end

    // Main FSM with registered outputs; soft Reset keeps the RR pointer.
    always_ff @(posedge clk) begin
        if (!rst_n || Reset) begin
            stateReg <= IDLE;
            gntReg   <= '0;
            doneReg  <= '0;
            cfgReg   <= 4'd15;
            rdWrReg  <= 1'b1;
            ifReqReg <= 1'b0;
            busyReg  <= 1'b0;
            cntReg   <= '0;
            if (!rst_n) begin
                rrPtrReg <= 2'd0;
            end
        end else begin
            case (stateReg)
                IDLE: begin
                    if (|bus.Req) begin
                        gntReg   <= winGnt;
                        cfgReg   <= winCfg;
                        rdWrReg  <= winRdWr;
                        ifReqReg <= 1'b1;
                        busyReg  <= 1'b1;
                        stateReg <= REQ;
                    end
                end
                REQ: begin
                    // A beat coinciding with IF_Rdy is not counted.
                    if (bus.IF_Rdy) begin
                        ifReqReg <= 1'b0;
                        cntReg   <= '0;
                        stateReg <= XFER;
                    end
                end
                XFER: begin
                    if (bus.IF_Val) begin
                        if (cntReg == LAST_BEAT) begin
                            cntReg   <= '0;
                            doneReg  <= gntReg;
                            stateReg <= DONE;
                        end else begin
                            cntReg <= cntReg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    doneReg  <= '0;
                    gntReg   <= '0;
                    cfgReg   <= 4'd15;
                    rdWrReg  <= 1'b1;
                    busyReg  <= 1'b0;
                    rrPtrReg <= rrAfter;
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign bus.IF_Req  = ifReqReg;
    assign bus.IF_Cfg  = cfgReg;
    assign bus.IF_RdWr = rdWrReg;
    assign bus.Gnt     = gntReg;
    assign bus.Done    = doneReg;
    assign bus.Busy    = busyReg;
    assign bus.BeatCnt = cntReg;
endmodule

// File: tb/tb_if_burst_sched.sv
// Bench for if_burst_sched with BURST_LEN=4: directed scenarios followed by
// randomized bursts, checked against a transaction-level reference model.
module tb_if_burst_sched;
    localparam int BL = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic Reset;

    if_burst_sched_if #(.CNT_W(CW)) bus();

    if_burst_sched #(.BURST_LEN(BL), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int rrModel    = 0;   // 0..3 -> next round-robin start is channel rrModel+1
    int cfgTab [7] = '{0, 8, 6, 4, 2, 10, 11};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference winner from the selection rules.
    function automatic int predict(input logic [6:0] r, input int p);
        if (r[5]) return 5;
        if (r[6]) return 6;
        if (r[0]) return 0;
        for (int o = 0; o < 4; o++) begin
            int c;
            c = 1 + (p + o) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic chkIdle(input string tag);
        chk({tag, ".busy"}, 32'(bus.Busy), 32'd0);
        chk({tag, ".gnt"},  32'(bus.Gnt), 32'd0);
        chk({tag, ".cfg"},  32'(bus.IF_Cfg), 32'd15);
        chk({tag, ".rdwr"}, 32'(bus.IF_RdWr), 32'd1);
        chk({tag, ".ifreq"},32'(bus.IF_Req), 32'd0);
        chk({tag, ".done"}, 32'(bus.Done), 32'd0);
        chk({tag, ".cnt"},  32'(bus.BeatCnt), 32'd0);
    endtask

    // One full transaction starting from IDLE. abortAt>=0 pulses Reset once
    // that many beats have been received.
    task automatic runBurst(input logic [6:0] req, input int rdyDly,
                            input bit randVal, input int abortAt);
        int w;
        int cnt;
        logic v;
        logic [6:0] g;
        w = predict(req, rrModel);
        g = 7'(1 << w);
        bus.Req = req;
        bus.IF_Val = 1'($urandom_range(0, 1));
        tick();
        bus.Req = 7'($urandom_range(0, 127));   // ignored after grant
        chk("req.ifreq", 32'(bus.IF_Req), 32'd1);
        chk("req.gnt",   32'(bus.Gnt), 32'(g));
        chk("req.cfg",   32'(bus.IF_Cfg), 32'(cfgTab[w]));
        chk("req.rdwr",  32'(bus.IF_RdWr), (w >= 5) ? 32'd0 : 32'd1);
        chk("req.busy",  32'(bus.Busy), 32'd1);
        for (int i = 0; i < rdyDly; i++) begin
            bus.IF_Val = 1'($urandom_range(0, 1));
            tick();
            chk("wait.ifreq", 32'(bus.IF_Req), 32'd1);
        end
        bus.IF_Rdy = 1'b1;
        bus.IF_Val = 1'($urandom_range(0, 1));
        tick();
        bus.IF_Rdy = 1'($urandom_range(0, 1));  // ignored in XFER
        chk("xfer.ifreq", 32'(bus.IF_Req), 32'd0);
        chk("xfer.cnt0",  32'(bus.BeatCnt), 32'd0);
        chk("xfer.gnt",   32'(bus.Gnt), 32'(g));
        cnt = 0;
        forever begin
            if (cnt == abortAt) begin
                Reset = 1'b1;
                bus.IF_Val = 1'($urandom_range(0, 1));
                tick();
                Reset = 1'b0;
                bus.IF_Val = 1'b0;
                bus.IF_Rdy = 1'b0;
                bus.Req = '0;
                chkIdle("abort");
                $display("burst req=%b gnt=%0d ABORTED after %0d beats", req, w, cnt);
                return;
            end
            v = randVal ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.IF_Val = v;
            tick();
            if (v) cnt++;
            if (cnt == BL) break;
            chk("beat.cnt",  32'(bus.BeatCnt), 32'(cnt));
            chk("beat.done", 32'(bus.Done), 32'd0);
        end
        chk("done.pulse", 32'(bus.Done), 32'(g));
        chk("done.cnt",   32'(bus.BeatCnt), 32'd0);
        chk("done.gnt",   32'(bus.Gnt), 32'(g));
        if (w >= 1 && w <= 4) rrModel = w % 4;
        bus.IF_Val = 1'b1;   // ignored outside XFER
        bus.IF_Rdy = 1'b0;
        tick();
        bus.IF_Val = 1'b0;
        bus.Req = '0;
        chkIdle("post");
        $display("burst req=%b gnt=%0d cfg=%0d beats=%0d done", req, w, cfgTab[w], cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        Reset = 1'b0;
        bus.Req = '0;
        bus.IF_Rdy = 1'b0;
        bus.IF_Val = 1'b0;
        tick();
        tick();
        chkIdle("reset");
        rst_n = 1'b1;
        tick();
        chkIdle("idle.noreq");

        // ACT single burst, IF_Rdy after two waiting cycles, back-to-back beats.
        runBurst(7'b0010000, 2, 1'b0, -1);
        // Round-robin over the four read-data channels.
        for (int i = 0; i < 5; i++) runBurst(7'b0011110, $urandom_range(0, 2), 1'b0, -1);
        // Fixed priority with requests dropping away.
        runBurst(7'b1100001, 0, 1'b1, -1);
        runBurst(7'b1100001, 1, 1'b1, -1);
        runBurst(7'b1000001, 0, 1'b1, -1);
        runBurst(7'b0000001, 0, 1'b1, -1);
        // Soft reset mid-burst keeps the RR pointer; next grant follows it.
        runBurst(7'b0011110, 0, 1'b0, 2);
        runBurst(7'b0011110, 0, 1'b0, -1);

        // Hard reset while IF_Rdy is asserted in REQ.
        bus.Req = 7'b0011110;
        tick();
        chk("hr.ifreq", 32'(bus.IF_Req), 32'd1);
        bus.IF_Rdy = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.IF_Rdy = 1'b0;
        bus.Req = '0;
        rrModel = 0;
        chkIdle("hardreset");
        tick();
        chkIdle("hardreset.stay");
        runBurst(7'b0011110, 0, 1'b0, -1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            logic [6:0] r;
            r = 7'($urandom_range(0, 127));
            if (r == 0) begin
                tick();
                chkIdle("rand.idle");
                $display("idle cycle with no requests");
            end else begin
                runBurst(r, $urandom_range(0, 3), 1'b1,
                         ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, BL - 1)) : -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
